alu_arbiter: RTL

- Shares one ALU instance between two requesters, for example the instruction pipeline and the address/DMA engine.
- Round-robin arbitration with a fixed 3-state sequencer: latch operands, execute, respond.
- Keeps a per-requester carry register, so multi-word ADDCU/ADDCUI chains from one requester are not corrupted by the other requester's operations.
- Sits between the requesters and the combinational ALU. All ALU inputs are registered, so the ALU path is a clean single cycle.

---
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of signals between the ALU arbiter, its two requesters and the shared combinational ALU.
// Handshake: a requester holds Req[i] with stable Opcode/A/B until it sees Grant[i] in the same cycle; Done[i] marks Result/Flags valid.
interface alu_arbiter_if #(parameter int WIDTH = 16);
  logic [1:0]       Req;
  logic [1:0]       Grant;
  logic [1:0]       Done;
  logic [1:0]       CarryClr;
  logic [7:0]       Opcode0;
  logic [7:0]       Opcode1;
  logic [WIDTH-1:0] A0;
  logic [WIDTH-1:0] B0;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] B1;
  logic [WIDTH-1:0] Result;
  logic [4:0]       Flags;
  logic [WIDTH-1:0] AluA;
  logic [WIDTH-1:0] AluB;
  logic [7:0]       AluOpcode;
  logic             AluCarryIn;
  logic [WIDTH-1:0] AluC;
  logic             AluCarry;
  logic             AluFlag;
  logic             AluLow;
  logic             AluNegative;
  logic             AluZero;

  modport slave (
    input  Req, CarryClr, Opcode0, Opcode1, A0, B0, A1, B1,
    input  AluC, AluCarry, AluFlag, AluLow, AluNegative, AluZero,
    output Grant, Done, Result, Flags, AluA, AluB, AluOpcode, AluCarryIn
  );

  modport master (
    output Req, CarryClr, Opcode0, Opcode1, A0, B0, A1, B1,
    output AluC, AluCarry, AluFlag, AluLow, AluNegative, AluZero,
    input  Grant, Done, Result, Flags, AluA, AluB, AluOpcode, AluCarryIn
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// per-requester carry register so multi-word carry chains stay independent.
module alu_arbiter #(
  parameter logic [7:0] NOP_OPCODE = 8'h00,
  parameter int         WIDTH      = 16
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [4:0]       flags_q, flags_d;
  logic [1:0]       carry_q, carry_d;
  logic [7:0]       op_q, op_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             sel;

  assign bus.AluA       = a_q;
  assign bus.AluB       = b_q;
  assign bus.AluOpcode  = op_q;
  assign bus.AluCarryIn = carry_q[owner_q];
  assign bus.Result     = result_q;
  assign bus.Flags      = flags_q;
  assign state_o        = state_q;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    last_d    = last_q;
    owner_d   = owner_q;
    sel       = 1'b0;
    bus.Grant = 2'b00;
    bus.Done  = 2'b00;
    carry_d   = carry_q & ~bus.CarryClr;
    case (state_q)
      IDLE: begin
        if (bus.Req != 2'b00) begin
          // On a tie the requester that did not win last time goes next.
          sel       = (bus.Req == 2'b11) ? ~last_q : bus.Req[1];
          owner_d   = sel;
          last_d    = sel;
          op_d      = sel ? bus.Opcode1 : bus.Opcode0;
          a_d       = sel ? bus.A1 : bus.A0;
          b_d       = sel ? bus.B1 : bus.B0;
          bus.Grant = sel ? 2'b10 : 2'b01;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d          = bus.AluC;
        flags_d           = {bus.AluCarry, bus.AluFlag, bus.AluLow, bus.AluNegative, bus.AluZero};
        carry_d[owner_q]  = bus.AluCarry;
        state_d           = RESP;
      end
      RESP: begin
        bus.Done = owner_q ? 2'b10 : 2'b01;
        op_d     = NOP_OPCODE;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts in-flight work, so no pulse may escape in a reset cycle.
    if (reset) begin
      bus.Grant = 2'b00;
      bus.Done  = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      carry_q  <= 2'b00;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op_q     <= NOP_OPCODE;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      carry_q  <= carry_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

endmodule
